// File: rtl/calc_sequencer.sv
// Stack-calculator sequencer: pushes literals to an external byte queue, pops two operands into an ALU.
// States: IDLE accept | PUSH write literal | POP pop+start ALU | WAIT await alu_sync | WB write result.
module calc_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_type,
    input  logic [7:0]             cmd_data,
    input  logic [2:0]             cmd_aluop,
    output logic [1:0]             q_opcode,
    output logic [7:0]             q_back,
    output logic [2:0]             alu_opcode,
    output logic                   alu_start,
    input  logic                   alu_sync,
    input  logic [7:0]             alu_result,
    output logic                   res_valid,
    output logic [7:0]             res_data,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_TWO   = CW'(2);
    localparam logic [WW-1:0] W_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_WAIT, S_WB} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_clr;
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wait;
    logic [7:0]    r_q_back;
    logic [7:0]    r_res;
    logic [2:0]    r_aluop;
    logic          r_err;
    logic [1:0]    r_err_code;
    logic          w_accept;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign cmd_ready  = (r_state == S_IDLE) && !r_clr;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_push_ok  = r_count < C_DEPTH;
    assign w_pop_ok   = r_count >= C_TWO;
    assign q_back     = r_q_back;
    assign res_data   = r_res;
    assign alu_opcode = r_aluop;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign count      = r_count;

    always_comb begin
        w_next    = r_state;
        q_opcode  = 2'b00;
        alu_start = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // First cycle out of reset clears the external queue so it matches count=0
                if (r_clr) q_opcode = 2'b11;
                if (w_accept) begin
                    if (!cmd_type && w_push_ok) w_next = S_PUSH;
                    else if (cmd_type && w_pop_ok) w_next = S_POP;
                end
            end
            S_PUSH: begin
                q_opcode = 2'b01;
                w_next   = S_IDLE;
            end
            S_POP: begin
                q_opcode  = 2'b10;
                alu_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (alu_sync) w_next = S_WB;
                else if (r_wait == W_LAST) w_next = S_IDLE;
            end
            S_WB: begin
                q_opcode  = 2'b01;
                res_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_clr      <= 1'b1;
            r_count    <= '0;
            r_wait     <= '0;
            r_q_back   <= '0;
            r_res      <= '0;
            r_aluop    <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state <= w_next;
            r_clr   <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!cmd_type) begin
                            if (w_push_ok) r_q_back <= cmd_data;
                            else begin
                                r_err      <= 1'b1;
                                r_err_code <= 2'b10;
                            end
                        end else begin
                            if (w_pop_ok) r_aluop <= cmd_aluop;
                            else begin
                                r_err      <= 1'b1;
                                r_err_code <= 2'b01;
                            end
                        end
                    end
                end
                S_PUSH: if (w_push_ok) r_count <= r_count + 1'b1;
                S_POP: begin
                    if (w_pop_ok) r_count <= r_count - C_TWO;
                    r_wait <= '0;
                end
                S_WAIT: begin
                    if (alu_sync) begin
                        r_res    <= alu_result;
                        r_q_back <= alu_result;
                    end else if (r_wait == W_LAST) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'b11;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WB: if (w_push_ok) r_count <= r_count + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized bench for calc_sequencer; the reference keeps the queue contents as a SystemVerilog queue
// and derives every expected strobe, code and count from command-level rules.
module tb_calc_sequencer;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_type = 1'b0;
    logic [7:0] cmd_data = '0;
    logic [2:0] cmd_aluop = '0;
    logic [1:0] q_opcode;
    logic [7:0] q_back;
    logic [2:0] alu_opcode;
    logic       alu_start;
    logic       alu_sync = 1'b0;
    logic [7:0] alu_result = '0;
    logic       res_valid;
    logic [7:0] res_data;
    logic       err;
    logic [1:0] err_code;
    logic [3:0] count;

    calc_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_data(cmd_data), .cmd_aluop(cmd_aluop),
        .q_opcode(q_opcode), .q_back(q_back), .alu_opcode(alu_opcode),
        .alu_start(alu_start), .alu_sync(alu_sync), .alu_result(alu_result),
        .res_valid(res_valid), .res_data(res_data), .err(err),
        .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mq[$];
    int exp_code = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        alu_sync = 1'b0;
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_res", res_data, 0);
        chk("rst_code", err_code, 0);
        chk("rst_op", alu_opcode, 0);
        chk("rst_back", q_back, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        chk("clr_q", q_opcode, 3);
        chk("clr_ready", cmd_ready, 0);
        step();
        chk("post_clr_q", q_opcode, 0);
        chk("post_clr_ready", cmd_ready, 1);
        mq.delete();
        exp_code = 0;
    endtask

    task automatic idle_gap(input int n);
        cmd_type = 1'($urandom);
        cmd_data = 8'($urandom);
        for (int g = 0; g < n; g++) begin
            step();
            chk("gap_err", err, 0);
            chk("gap_q", q_opcode, 0);
        end
    endtask

    task automatic do_push(input logic [7:0] d);
        int n = mq.size();
        chk("push_ready", cmd_ready, 1);
        chk("code_hold", err_code, exp_code);
        cmd_valid = 1'b1;
        cmd_type  = 1'b0;
        cmd_data  = d;
        alu_sync  = 1'($urandom);
        step();
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        if (n < DEPTH) begin
            chk("push_q", q_opcode, 1);
            chk("push_back", q_back, d);
            chk("push_gap", cmd_ready, 0);
            chk("push_err", err, 0);
            mq.push_back(d);
            step();
            alu_sync = 1'b0;
            chk("push_done_ready", cmd_ready, 1);
            chk("push_done_q", q_opcode, 0);
            chk("push_count", count, mq.size());
        end else begin
            alu_sync = 1'b0;
            exp_code = 2;
            chk("ovf_err", err, 1);
            chk("ovf_code", err_code, 2);
            chk("ovf_q", q_opcode, 0);
            chk("ovf_ready", cmd_ready, 1);
            chk("ovf_count", count, n);
        end
    endtask

    task automatic do_exec(input logic [2:0] op, input int delay, input logic [7:0] res);
        int n = mq.size();
        chk("exec_ready", cmd_ready, 1);
        chk("code_hold", err_code, exp_code);
        cmd_valid = 1'b1;
        cmd_type  = 1'b1;
        cmd_aluop = op;
        step();
        cmd_valid = 1'b0;
        cmd_aluop = 3'($urandom);
        if (n < 2) begin
            exp_code = 1;
            chk("unf_err", err, 1);
            chk("unf_code", err_code, 1);
            chk("unf_start", alu_start, 0);
            chk("unf_q", q_opcode, 0);
            chk("unf_count", count, n);
            chk("unf_ready", cmd_ready, 1);
            return;
        end
        chk("pop_q", q_opcode, 2);
        chk("pop_start", alu_start, 1);
        chk("pop_op", alu_opcode, op);
        chk("pop_count", count, n);
        void'(mq.pop_front());
        void'(mq.pop_front());
        alu_sync   = 1'($urandom);
        alu_result = 8'($urandom);
        step();
        chk("wait_count", count, mq.size());
        for (int i = 0; i < TIMEOUT; i++) begin
            alu_sync = (i == delay);
            if (i == delay) alu_result = res;
            chk("wait_q", q_opcode, 0);
            chk("wait_err", err, 0);
            step();
            alu_sync   = 1'b0;
            alu_result = 8'($urandom);
            if (i == delay) break;
        end
        if (delay < TIMEOUT) begin
            chk("wb_q", q_opcode, 1);
            chk("wb_back", q_back, res);
            chk("wb_rv", res_valid, 1);
            chk("wb_res", res_data, res);
            chk("wb_op", alu_opcode, op);
            mq.push_back(res);
            step();
            chk("wb_done_q", q_opcode, 0);
            chk("wb_done_rv", res_valid, 0);
            chk("wb_done_ready", cmd_ready, 1);
            chk("wb_count", count, mq.size());
            chk("res_hold", res_data, res);
        end else begin
            exp_code = 3;
            chk("to_err", err, 1);
            chk("to_code", err_code, 3);
            chk("to_ready", cmd_ready, 1);
            chk("to_rv", res_valid, 0);
            chk("to_q", q_opcode, 0);
            chk("to_count", count, mq.size());
        end
    endtask

    task automatic exec_reset(input int extra);
        chk("xr_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_type  = 1'b1;
        cmd_aluop = 3'($urandom);
        step();
        cmd_valid = 1'b0;
        chk("xr_pop", q_opcode, 2);
        step();
        for (int i = 0; i < extra; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        alu_sync   = 1'b1;
        alu_result = 8'($urandom);
        chk("xr_clr_q", q_opcode, 3);
        chk("xr_clr_rv", res_valid, 0);
        chk("xr_clr_count", count, 0);
        chk("xr_clr_ready", cmd_ready, 0);
        step();
        alu_sync = 1'b0;
        chk("xr_rv", res_valid, 0);
        chk("xr_q", q_opcode, 0);
        chk("xr_count", count, 0);
        chk("xr_ready2", cmd_ready, 1);
        chk("xr_res", res_data, 0);
        chk("xr_code", err_code, 0);
        mq.delete();
        exp_code = 0;
    endtask

    initial begin
        do_reset();
        do_push(8'h01);
        do_push(8'h02);
        chk("dir_count2", count, 2);
        do_exec(3'd2, 1, 8'h03);
        chk("dir_count1", count, 1);

        do_reset();
        do_push(8'h55);
        do_exec(3'd5, 0, 8'h00);
        chk("dir_unf_count", count, 1);

        do_reset();
        for (int i = 0; i < DEPTH; i++) do_push(8'($urandom));
        do_push(8'hAA);
        chk("dir_full", count, DEPTH);
        do_exec(3'd1, TIMEOUT, 8'h00);
        chk("dir_to_count", count, DEPTH - 2);
        do_exec(3'd6, TIMEOUT - 1, 8'h7E);
        exec_reset(2);

        for (int k = 0; k < 300; k++) begin
            int r = $urandom_range(0, 99);
            if (r < 4 && mq.size() >= 2) begin
                exec_reset($urandom_range(0, TIMEOUT - 2));
            end else if (r < 55) begin
                do_push(8'($urandom));
            end else begin
                int sel = $urandom_range(0, 9);
                int dly = (sel < 8) ? $urandom_range(0, 4) :
                          (sel == 8) ? TIMEOUT - 1 : TIMEOUT + 3;
                do_exec(3'($urandom), dly, 8'($urandom));
            end
            idle_gap($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: queue capacity in bytes; the occupancy counter is $clog2(DEPTH)+1 bits wide.
REQ-002 Parameter TIMEOUT, default 16: maximum number of cycles spent waiting for ALU sync.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_type  in  1  0 = push literal, 1 = execute ALU op.
REQ-008 cmd_data  in  8  literal for push.
REQ-009 cmd_aluop  in  3  ALU opcode for execute.
REQ-010 q_opcode  out  2  queue command: 00 hold, 01 push back, 10 pop two, 11 clear.
REQ-011 q_back  out  8  byte pushed into the queue.
REQ-012 alu_opcode  out  3  opcode presented to the ALU.
REQ-013 alu_start  out  1  one-cycle start strobe to the ALU.
REQ-014 alu_sync  in  1  ALU result-ready strobe.
REQ-015 alu_result  in  8  ALU result byte.
REQ-016 res_valid  out  1  one-cycle strobe; res_data is valid.
REQ-017 res_data  out  8  last computed result.
REQ-018 err  out  1  one-cycle error strobe.
REQ-019 err_code  out  2  error cause: 01 underflow, 10 overflow, 11 timeout; holds until the next error or reset.
REQ-020 count  out  4  tracked queue occupancy, 0..DEPTH.

Function
REQ-021 States: IDLE, PUSH, POP, WAIT, WB. The FSM SHALL be one-hot or binary encoded.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready on a clock edge.
REQ-023 q_opcode SHALL be 00, and alu_start, res_valid and err SHALL be 0, in every cycle not listed below.
REQ-024 Push accepted with count < DEPTH: IDLE -> PUSH. In PUSH, q_opcode=01 and q_back=cmd_data for exactly one cycle; count increments; next state IDLE.
REQ-025 Push accepted with count == DEPTH: the command is dropped; err=1 and err_code=10 in the next cycle; state stays IDLE; count is unchanged.
REQ-026 Execute accepted with count < 2: the command is dropped; err=1 and err_code=01 in the next cycle; state stays IDLE.
REQ-027 Execute accepted with count >= 2: IDLE -> POP. cmd_aluop is latched into alu_opcode, which holds until WB exits.
REQ-028 POP lasts one cycle, with alu_start=1 and q_opcode=10; count decrements by 2; next state WAIT. The ALU samples its operands in this cycle.
REQ-029 WAIT: on alu_sync=1, latch alu_result into res_data and go to WB. A wait counter starts at 0 on entry.
REQ-030 If the wait counter reaches TIMEOUT-1 without alu_sync: err=1, err_code=11, return to IDLE with no push. The operands are lost and count keeps its post-pop value.
REQ-031 WB lasts one cycle, with q_opcode=01, q_back=res_data and res_valid=1; count increments; next state IDLE. Overflow is impossible here because two entries were popped.
REQ-032 Latency: push takes 2 cycles from acceptance to cmd_ready high again. Execute takes 3 cycles plus the alu_sync wait.
REQ-033 An alu_sync outside WAIT SHALL be ignored.
REQ-034 cmd_* inputs SHALL be ignored outside the acceptance cycle. cmd_data is registered at acceptance.
REQ-035 count SHALL never wrap: it saturates at DEPTH and never goes below 0 by construction.

Reset
REQ-036 While rst=1 at a clock edge: state=IDLE, count=0, res_data=0, err_code=00, alu_opcode=0, q_back=0, wait counter=0, and all strobes are 0.
REQ-037 In the first cycle after rst deasserts, q_opcode=11 (clear) for one cycle with cmd_ready=0, so the queue and count agree. The block then enters IDLE.
REQ-038 Reset during WAIT or WB SHALL abort the operation: no res_valid and no push in the cycle after reset.

Verification
REQ-039 Reset, then push 8'h01 and 8'h02 -> q_opcode=01 with q_back 01 then 02, count=2, cmd_ready gap of 1 cycle after each push.
REQ-040 Count=2, execute op 3'd2, alu_sync returned 2 cycles after alu_start with result 8'h03 -> POP with q_opcode=10, then WB with q_back=03, res_valid=1, res_data=03, count=1.
REQ-041 Reset, then execute with count=1 -> err=1, err_code=01, no alu_start, count remains 1.
REQ-042 Push 8 literals, then a 9th push -> err=1, err_code=10, no q_opcode=01 for the 9th, count=8.
REQ-043 Execute with alu_sync held 0 -> err=1 with err_code=11 after TIMEOUT cycles in WAIT, no WB, count reduced by 2, cmd_ready=1 next cycle.
REQ-044 Assert rst during WAIT, then pulse alu_sync -> no res_valid, one-cycle q_opcode=11 after release, count=0.
